// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit: encodings, FSM states
// and the per-state datapath strobe table.
package mips_multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [2:0] ALU_NONE = 3'b000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_HALT   = 4'd10
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
  } ctrl_t;

  // Moore strobe table; anything not named for a state stays 0.
  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_write  = 1'b1;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD:  c.iord = 1'b1;
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC:   c.alu_src_a = 1'b1;
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// ALU control decoder: ALUOp selects add, sub or a Funct-driven operation and
// flags Funct codes outside the supported subset.
module mips_multicycle_control_alu_decoder
  import mips_multicycle_control_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       legal_o
);

  // Operation select and legality
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    legal_o    = 1'b1;
    case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: legal_o = 1'b0;
        endcase
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/execute,
// counts retired instructions and latches a sticky halt on illegal encodings.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUCtrl,
  output logic             Halt,
  output logic [CNT_W-1:0] InstrCount
);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;
  logic             halt_q;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       alu_op_s;
  logic [2:0]       dec_ctrl_s;
  logic             dec_legal_s;
  logic             retire_s;

  // In DECODE the decoder runs in Funct mode: its result is both the legality
  // check and the ALUCtrl value registered for EXEC.
  assign alu_op_s = (state_q == S_DECODE) ? ALUOP_FUNCT : ALUOP_ADD;

  mips_multicycle_control_alu_decoder u_alu_dec (
    .alu_op_i   (alu_op_s),
    .funct_i    (Funct),
    .alu_ctrl_o (dec_ctrl_s),
    .legal_o    (dec_legal_s)
  );

  // Next-state logic
  always_comb begin
    state_d = S_HALT;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = dec_legal_s ? S_EXEC : S_HALT;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // ALU operation for the state being entered
  always_comb begin
    alu_ctrl_d = ALU_NONE;
    case (state_d)
      S_FETCH, S_DECODE, S_MEMADR: alu_ctrl_d = ALU_ADD;
      S_EXEC:   alu_ctrl_d = dec_ctrl_s;
      S_BRANCH: alu_ctrl_d = ALU_SUB;
      default:  alu_ctrl_d = ALU_NONE;
    endcase
  end

  assign retire_s = (state_q == S_MEMWB) || (state_q == S_MEMWR) ||
                    (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                    (state_q == S_JUMP);

  // State, registered strobes, halt flag and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      ctrl_q     <= state_ctrl(S_FETCH);
      alu_ctrl_q <= ALU_ADD;
      halt_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= state_ctrl(state_d);
      alu_ctrl_q <= alu_ctrl_d;
      halt_q     <= (state_d == S_HALT);
      if (retire_s) begin
        count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign PCEn       = ctrl_q.pc_write | (ctrl_q.branch & Zero);
  assign IorD       = ctrl_q.iord;
  assign MemWrite   = ctrl_q.mem_write;
  assign IRWrite    = ctrl_q.ir_write;
  assign RegDst     = ctrl_q.reg_dst;
  assign MemtoReg   = ctrl_q.mem_to_reg;
  assign RegWrite   = ctrl_q.reg_write;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign PCSrc      = ctrl_q.pc_src;
  assign ALUCtrl    = alu_ctrl_q;
  assign Halt       = halt_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: directed and randomized
// instruction streams compared against a phase-level reference model.
module tb_mips_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  Op = 6'd0;
  logic [5:0]  Funct = 6'd0;
  logic        Zero = 1'b0;
  logic        PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Halt;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALUCtrl;
  logic [31:0] InstrCount;
  logic [15:0] obs;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_cnt = 32'd0;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                P_EXEC, P_ALUWB, P_BRANCH, P_JUMP, P_HALT} phase_t;

  mips_multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUCtrl(ALUCtrl), .Halt(Halt),
    .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  assign obs = {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, PCSrc, ALUCtrl, Halt};

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] funct_op(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'bxxx;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] f);
    if (op == 6'b100011 || op == 6'b101011 || op == 6'b000100 || op == 6'b000010) return 1'b1;
    if (op == 6'b000000 && (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                            f == 6'b100101 || f == 6'b101010)) return 1'b1;
    return 1'b0;
  endfunction

  // Expected strobes for one cycle of a given phase, straight from the state table
  function automatic logic [15:0] expect_out(input phase_t ph, input logic [5:0] f, input logic z);
    logic pcen, iord, memw, irw, rdst, m2r, regw, srca, hlt;
    logic [1:0] srcb, pcsrc;
    logic [2:0] aluc;
    {pcen, iord, memw, irw, rdst, m2r, regw, srca, hlt} = 9'd0;
    srcb = 2'b00; pcsrc = 2'b00; aluc = 3'b000;
    case (ph)
      P_FETCH:  begin pcen = 1'b1; irw = 1'b1; srcb = 2'b01; aluc = 3'b010; end
      P_DECODE: begin srcb = 2'b11; aluc = 3'b010; end
      P_MEMADR: begin srca = 1'b1; srcb = 2'b10; aluc = 3'b010; end
      P_MEMRD:  iord = 1'b1;
      P_MEMWB:  begin m2r = 1'b1; regw = 1'b1; end
      P_MEMWR:  begin iord = 1'b1; memw = 1'b1; end
      P_EXEC:   begin srca = 1'b1; aluc = funct_op(f); end
      P_ALUWB:  begin rdst = 1'b1; regw = 1'b1; end
      P_BRANCH: begin srca = 1'b1; aluc = 3'b110; pcsrc = 2'b01; pcen = z; end
      P_JUMP:   begin pcsrc = 2'b10; pcen = 1'b1; end
      P_HALT:   hlt = 1'b1;
      default:  hlt = 1'b0;
    endcase
    return {pcen, iord, memw, irw, rdst, m2r, regw, srca, srcb, pcsrc, aluc, hlt};
  endfunction

  // Phase sequence of one instruction; illegal ones show three halt cycles
  function automatic int plan(input logic [5:0] op, input logic [5:0] f, output phase_t ph[5]);
    ph[0] = P_FETCH; ph[1] = P_DECODE; ph[2] = P_HALT; ph[3] = P_HALT; ph[4] = P_HALT;
    if (!is_legal(op, f)) return 5;
    case (op)
      6'b100011: begin ph[2] = P_MEMADR; ph[3] = P_MEMRD; ph[4] = P_MEMWB; return 5; end
      6'b101011: begin ph[2] = P_MEMADR; ph[3] = P_MEMWR; return 4; end
      6'b000000: begin ph[2] = P_EXEC; ph[3] = P_ALUWB; return 4; end
      6'b000100: begin ph[2] = P_BRANCH; return 3; end
      default:   begin ph[2] = P_JUMP; return 3; end
    endcase
  endfunction

  task automatic reset_dut();
    reset = 1'b1;
    Op = 6'($urandom); Funct = 6'($urandom); Zero = 1'($urandom);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic sample(input logic [5:0] op, input logic [5:0] f, input logic z);
    Op = op; Funct = f; Zero = z;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_dut();
    sample(6'($urandom), 6'($urandom), 1'b0);
    n_vec++;
    if (obs !== expect_out(P_FETCH, 6'd0, 1'b0)) begin
      n_err++; $display("FAIL reset_outputs got=%h exp=%h", obs, expect_out(P_FETCH, 6'd0, 1'b0));
    end
    n_vec++;
    if (InstrCount !== 32'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", InstrCount); end
    advance();
  endtask

  // Back-to-back directed instructions with Zero held per instruction
  task automatic test_directed();
    logic [5:0] t_op[10] = '{6'b100011, 6'b000000, 6'b000100, 6'b000100, 6'b101011,
                             6'b000010, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    logic [5:0] t_fn[10] = '{6'h15, 6'b101010, 6'h15, 6'h15, 6'h15,
                             6'h15, 6'b100000, 6'b100010, 6'b100100, 6'b100101};
    logic       t_z[10]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    phase_t ph[5];
    int n;
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      n = plan(t_op[k], t_fn[k], ph);
      for (int i = 0; i < n; i++) begin
        sample(t_op[k], t_fn[k], t_z[k]);
        n_vec++;
        if (obs !== expect_out(ph[i], t_fn[k], t_z[k])) begin
          n_err++;
          $display("FAIL directed op=%b fn=%b %s got=%h exp=%h", t_op[k], t_fn[k],
                   ph[i].name(), obs, expect_out(ph[i], t_fn[k], t_z[k]));
        end
        n_vec++;
        if (InstrCount !== exp_cnt) begin
          n_err++; $display("FAIL directed_count %s got=%0d exp=%0d", ph[i].name(), InstrCount, exp_cnt);
        end
        advance();
      end
      exp_cnt++;
    end
    sample(6'b000010, 6'd0, 1'b0);
    n_vec++;
    if (InstrCount !== 32'd10 || obs !== expect_out(P_FETCH, 6'd0, 1'b0)) begin
      n_err++; $display("FAIL directed_final count=%0d exp=10 out=%h", InstrCount, obs);
    end
    advance();
  endtask

  // Illegal opcode and illegal funct: halt at cycle 3, frozen for 20 cycles, reset clears
  task automatic test_halt();
    logic [5:0] h_op[2] = '{6'b111111, 6'b000000};
    logic [5:0] h_fn[2] = '{6'b101010, 6'b000000};
    for (int k = 0; k < 2; k++) begin
      reset_dut();
      for (int i = 0; i < 3; i++) begin
        sample(6'b000010, 6'd0, 1'($urandom));
        advance();
      end
      exp_cnt = 32'd1;
      for (int i = 0; i < 22; i++) begin
        if (i < 2) sample(h_op[k], h_fn[k], 1'($urandom));
        else sample(6'($urandom), 6'($urandom), 1'($urandom));
        n_vec++;
        if (obs !== expect_out(i == 0 ? P_FETCH : (i == 1 ? P_DECODE : P_HALT), h_fn[k], Zero)) begin
          n_err++; $display("FAIL halt%0d cyc%0d got=%h", k, i, obs);
        end
        n_vec++;
        if (InstrCount !== exp_cnt) begin
          n_err++; $display("FAIL halt_count%0d cyc%0d got=%0d exp=%0d", k, i, InstrCount, exp_cnt);
        end
        advance();
      end
      reset_dut();
      sample(6'b000010, 6'd0, 1'b0);
      n_vec++;
      if (obs !== expect_out(P_FETCH, 6'd0, 1'b0) || InstrCount !== 32'd0) begin
        n_err++; $display("FAIL halt_clear%0d got=%h count=%0d", k, obs, InstrCount);
      end
      advance();
    end
  endtask

  // Reset asserted during the store's write cycle must drop MemWrite at once
  task automatic test_reset_in_memwr();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      sample(6'b101011, 6'd0, 1'b0);
      advance();
    end
    Op = 6'b101011; Zero = 1'b0;
    #2;
    n_vec++;
    if (MemWrite !== 1'b1) begin n_err++; $display("FAIL memwr_before got=%b exp=1", MemWrite); end
    reset = 1'b1;
    #1;
    n_vec++;
    if (obs !== expect_out(P_FETCH, 6'd0, 1'b0)) begin
      n_err++; $display("FAIL memwr_reset got=%h exp=%h", obs, expect_out(P_FETCH, 6'd0, 1'b0));
    end
    advance();
    reset = 1'b0;
    sample(6'b000010, 6'd0, 1'b0);
    n_vec++;
    if (obs !== expect_out(P_FETCH, 6'd0, 1'b0) || InstrCount !== 32'd0) begin
      n_err++; $display("FAIL memwr_release got=%h count=%0d exp count=0", obs, InstrCount);
    end
    advance();
  endtask

  // Random instruction stream, garbage IR during FETCH, Zero toggling every cycle
  task automatic test_random();
    logic [5:0] legal_fn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] ops[4] = '{6'b100011, 6'b101011, 6'b000100, 6'b000010};
    logic [5:0] op, fn;
    logic z;
    phase_t ph[5];
    int n, kind;
    reset_dut();
    for (int k = 0; k < 150; k++) begin
      kind = $urandom_range(0, 19);
      fn = 6'($urandom);
      if (kind < 8) op = ops[kind % 4];
      else if (kind < 17) begin op = 6'b000000; fn = legal_fn[$urandom_range(0, 4)]; end
      else if (kind < 18) op = 6'b000000;
      else begin
        op = 6'($urandom);
        while (is_legal(op, fn)) op = 6'($urandom);
      end
      n = plan(op, fn, ph);
      for (int i = 0; i < n; i++) begin
        z = 1'($urandom);
        if (i == 0) sample(6'($urandom), 6'($urandom), z);
        else sample(op, fn, z);
        n_vec++;
        if (obs !== expect_out(ph[i], fn, z)) begin
          n_err++;
          $display("FAIL random#%0d op=%b fn=%b %s got=%h exp=%h", k, op, fn,
                   ph[i].name(), obs, expect_out(ph[i], fn, z));
        end
        n_vec++;
        if (InstrCount !== exp_cnt) begin
          n_err++; $display("FAIL random_count#%0d %s got=%0d exp=%0d", k, ph[i].name(), InstrCount, exp_cnt);
        end
        advance();
      end
      if (is_legal(op, fn)) exp_cnt++;
      else reset_dut();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_halt();
    test_reset_in_memwr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
